// File: rtl/neo_pixel_strand_controller.sv
// rtl/neo_pixel_strand_controller.sv - five-pixel NeoPixel strand driver with load/send control
module neo_pixel_strand_controller (
   input  logic         clock,
   input  logic         reset,
   input  logic [7:0]   color_level,
   input  logic [1:0]   color_index,
   input  logic [2:0]   pixel_index,
   input  logic         load_color,
   input  logic         send_it,
   output logic         neo_data,
   output logic         ready_to_load,
   output logic         ready_to_send,
   output logic [119:0] display_packet
);

   localparam logic [6:0]  BIT_FIRST  = 7'd119;
   localparam logic [5:0]  CYC_LAST   = 6'd62;
   localparam logic [5:0]  HIGH_ZERO  = 6'd18;
   localparam logic [5:0]  HIGH_ONE   = 6'd35;
   localparam logic [11:0] LATCH_LAST = 12'd2499;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SEND   = 2'd1,
      WAIT50 = 2'd2
   } state_t;

   state_t       state_q, state_d;
   logic [119:0] packet_q, packet_d;
   logic [6:0]   bit_q, bit_d;
   logic [5:0]   cyc_q, cyc_d;
   logic [11:0]  wait_q, wait_d;
   logic         neo_q, neo_d;
   logic         ready_q, ready_d;
   logic         load_ok;
   logic [6:0]   color_off;
   logic [6:0]   load_msb;
   logic [5:0]   high_len;

   // Each pixel occupies 24 bits as {G,R,B}; green sits at the top of the slot.
   always_comb begin
      color_off = 7'd0;
      case (color_index)
         2'b00:   color_off = 7'd8;
         2'b01:   color_off = 7'd16;
         default: color_off = 7'd0;
      endcase
   end

   assign load_ok  = load_color && (color_index != 2'b11) && (pixel_index <= 3'd4);
   assign load_msb = BIT_FIRST - (7'(pixel_index) * 7'd24) - color_off;

   always_comb begin
      state_d  = state_q;
      packet_d = packet_q;
      bit_d    = bit_q;
      cyc_d    = cyc_q;
      wait_d   = wait_q;
      high_len = HIGH_ZERO;
      neo_d    = 1'b0;
      ready_d  = 1'b0;

      case (state_q)
         IDLE: begin
            if (send_it) begin
               state_d = SEND;
               bit_d   = BIT_FIRST;
               cyc_d   = 6'd0;
            end else if (load_ok) begin
               packet_d[load_msb -: 8] = color_level;
            end
         end
         SEND: begin
            if (cyc_q == CYC_LAST) begin
               cyc_d = 6'd0;
               if (bit_q == 7'd0) begin
                  state_d = WAIT50;
                  wait_d  = 12'd0;
               end else begin
                  bit_d = bit_q - 7'd1;
               end
            end else begin
               cyc_d = cyc_q + 6'd1;
            end
         end
         WAIT50: begin
            if (wait_q == LATCH_LAST) begin
               state_d = IDLE;
               wait_d  = 12'd0;
            end else begin
               wait_d = wait_q + 12'd1;
            end
         end
         default: state_d = IDLE;
      endcase

      // Outputs are computed from next-state values so the data line comes straight from a flop.
      if (packet_q[bit_d]) begin
         high_len = HIGH_ONE;
      end
      neo_d   = (state_d == SEND) && (cyc_d < high_len);
      ready_d = (state_d == IDLE);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= IDLE;
         packet_q <= '0;
         bit_q    <= '0;
         cyc_q    <= '0;
         wait_q   <= '0;
         neo_q    <= 1'b0;
         ready_q  <= 1'b1;
      end else begin
         state_q  <= state_d;
         packet_q <= packet_d;
         bit_q    <= bit_d;
         cyc_q    <= cyc_d;
         wait_q   <= wait_d;
         neo_q    <= neo_d;
         ready_q  <= ready_d;
      end
   end

   assign neo_data       = neo_q;
   assign ready_to_load  = ready_q;
   assign ready_to_send  = ready_q;
   assign display_packet = packet_q;

endmodule

// File: tb/tb_neo_pixel_strand_controller.sv
// tb/tb_neo_pixel_strand_controller.sv - scoreboard bench for the NeoPixel strand controller
module tb_neo_pixel_strand_controller;

   logic         clock = 1'b0;
   logic         reset;
   logic [7:0]   color_level;
   logic [1:0]   color_index;
   logic [2:0]   pixel_index;
   logic         load_color;
   logic         send_it;
   logic         neo_data;
   logic         ready_to_load;
   logic         ready_to_send;
   logic [119:0] display_packet;

   int checks = 0;
   int errors = 0;

   logic [119:0] pkt_q[$];
   logic         exp_bits[$];
   int           frame_q[$];

   logic [7:0] m_g[5];
   logic [7:0] m_r[5];
   logic [7:0] m_b[5];

   always #10 clock = ~clock;

   neo_pixel_strand_controller dut (
      .clock          (clock),
      .reset          (reset),
      .color_level    (color_level),
      .color_index    (color_index),
      .pixel_index    (pixel_index),
      .load_color     (load_color),
      .send_it        (send_it),
      .neo_data       (neo_data),
      .ready_to_load  (ready_to_load),
      .ready_to_send  (ready_to_send),
      .display_packet (display_packet)
   );

   task automatic chk(input string name, input logic [119:0] act, input logic [119:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   function automatic logic [119:0] model_packet();
      logic [119:0] p;
      p = '0;
      for (int i = 0; i < 5; i++) p = {p[95:0], m_g[i], m_r[i], m_b[i]};
      return p;
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 5; i++) begin
         m_g[i] = 8'h00;
         m_r[i] = 8'h00;
         m_b[i] = 8'h00;
      end
   endtask

   task automatic model_load(input int pix, input int idx, input logic [7:0] lvl);
      if (pix <= 4) begin
         case (idx)
            0: m_r[pix] = lvl;
            1: m_b[pix] = lvl;
            2: m_g[pix] = lvl;
            default: ;
         endcase
      end
   endtask

   task automatic cycle();
      @(posedge clock);
      #2;
   endtask

   task automatic do_load(input int pix, input int idx, input logic [7:0] lvl);
      pixel_index = 3'(pix);
      color_index = 2'(idx);
      color_level = lvl;
      load_color  = 1'b1;
      cycle();
      load_color = 1'b0;
      model_load(pix, idx, lvl);
      pkt_q.push_back(model_packet());
   endtask

   task automatic do_send(input bit with_load);
      logic [119:0] p;
      p = model_packet();
      for (int i = 119; i >= 0; i--) exp_bits.push_back(p[i]);
      frame_q.push_back(120);
      send_it     = 1'b1;
      load_color  = with_load;
      pixel_index = 3'($urandom_range(0, 4));
      color_index = 2'($urandom_range(0, 2));
      color_level = 8'($urandom);
      cycle();
      send_it    = 1'b0;
      load_color = 1'b0;
      pkt_q.push_back(model_packet());
      chk("send_ready_to_send", 120'(ready_to_send), 120'(0));
      chk("send_ready_to_load", 120'(ready_to_load), 120'(0));
      chk("send_first_high", 120'(neo_data), 120'(1));
   endtask

   // Waits for the strand to return to IDLE, optionally poking load/send while busy.
   task automatic wait_done(input bit noisy);
      int n;
      n = 0;
      while (!ready_to_send && n < 10200) begin
         if (noisy && $urandom_range(0, 299) == 0) begin
            load_color  = 1'b1;
            send_it     = 1'($urandom_range(0, 1));
            pixel_index = 3'($urandom_range(0, 4));
            color_index = 2'($urandom_range(0, 2));
            color_level = 8'($urandom);
         end
         cycle();
         n++;
         if (load_color) pkt_q.push_back(model_packet());
         load_color = 1'b0;
         send_it    = 1'b0;
      end
      chk("frame_len", 120'(n), 120'(10060));
      chk("idle_ready_to_load", 120'(ready_to_load), 120'(1));
      chk("idle_neo", 120'(neo_data), 120'(0));
   endtask

   initial begin : monitor
      logic prev_neo;
      bit   in_frame;
      logic b;
      int   pulses, hi, lo, exp_lo, nfr;
      prev_neo = 1'b0;
      in_frame = 1'b0;
      pulses = 0; hi = 0; lo = 0; exp_lo = 0; nfr = 0;
      forever begin
         @(negedge clock);
         if (reset) begin
            pkt_q.delete();
            exp_bits.delete();
            frame_q.delete();
            in_frame = 1'b0;
            prev_neo = 1'b0;
         end else begin
            if (pkt_q.size() > 0) chk("packet", display_packet, pkt_q.pop_front());
            if (!ready_to_send && !in_frame) begin
               in_frame = 1'b1;
               pulses = 0; hi = 0; lo = 0; exp_lo = 0;
            end
            if (in_frame && ready_to_send) begin
               in_frame = 1'b0;
               nfr = (frame_q.size() > 0) ? frame_q.pop_front() : -1;
               chk("pulse_count", 120'(pulses), 120'(nfr));
               chk("latch_low", 120'(lo), 120'(exp_lo + 2500));
            end else if (in_frame) begin
               if (neo_data) begin
                  if (!prev_neo) begin
                     if (pulses > 0) chk("bit_low", 120'(lo), 120'(exp_lo));
                     pulses++;
                     hi = 0;
                  end
                  hi++;
               end else begin
                  if (prev_neo) begin
                     if (exp_bits.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL extra_pulse actual=%0d pulses expected=120", pulses);
                        b = 1'b0;
                     end else begin
                        b = exp_bits.pop_front();
                     end
                     chk("bit_high", 120'(hi), b ? 120'(35) : 120'(18));
                     exp_lo = b ? 28 : 45;
                     lo = 0;
                  end
                  lo++;
               end
            end
            prev_neo = neo_data;
         end
      end
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "bench did not finish");
   end

   initial begin : stimulus
      reset       = 1'b1;
      load_color  = 1'b0;
      send_it     = 1'b0;
      color_level = 8'h00;
      color_index = 2'b00;
      pixel_index = 3'd0;
      model_clear();
      repeat (3) cycle();
      reset = 1'b0;
      pkt_q.push_back(model_packet());
      chk("reset_packet", display_packet, 120'h0);
      chk("reset_ready_to_load", 120'(ready_to_load), 120'(1));
      chk("reset_ready_to_send", 120'(ready_to_send), 120'(1));
      chk("reset_neo", 120'(neo_data), 120'(0));

      do_load(4, 0, 8'hFF);
      do_load(0, 1, 8'h73);
      do_load(2, 2, 8'hB3);
      do_load(1, 3, 8'hD4);
      do_load(0, 0, 8'h50);
      chk("directed_packet", display_packet, 120'h005073_000000_B30000_000000_00FF00);
      do_load(5, 0, 8'hAA);
      do_load(7, 1, 8'h11);

      do_send(1'b0);
      wait_done(1'b1);

      for (int i = 0; i < 30; i++) begin
         do_load(int'($urandom_range(0, 7)), int'($urandom_range(0, 3)), 8'($urandom));
      end
      do_send(1'b1);
      wait_done(1'b0);
      do_send(1'b0);
      wait_done(1'b1);

      do_send(1'b0);
      repeat ($urandom_range(50, 9500)) cycle();
      reset = 1'b1;
      cycle();
      reset = 1'b0;
      model_clear();
      pkt_q.push_back(model_packet());
      chk("abort_neo", 120'(neo_data), 120'(0));
      chk("abort_ready_to_load", 120'(ready_to_load), 120'(1));
      chk("abort_ready_to_send", 120'(ready_to_send), 120'(1));
      chk("abort_packet", display_packet, 120'h0);

      for (int i = 0; i < 8; i++) begin
         do_load(int'($urandom_range(0, 4)), int'($urandom_range(0, 3)), 8'($urandom));
      end
      repeat (3) cycle();
      chk("bits_left", 120'(exp_bits.size()), 120'(0));
      chk("frames_left", 120'(frame_q.size()), 120'(0));
      chk("packets_left", 120'(pkt_q.size()), 120'(0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
